wt_inval_queue: RTL and testbench

Buffers cache-line invalidation requests from the memory-side coherence source before they reach the write-through cache subsystem's `inval_addr_i`/`inval_valid_i`/`inval_ready_o` port. It decouples the bursty snoop source from the cache, which can stall invalidations while its tag pipeline is busy. It line-aligns every address, holds up to `DEPTH` requests in order, and optionally suppresses back-to-back duplicate lines.

---
 rtl/wt_cache_pkg.sv | 10 +
 rtl/fifo_v3.sv | 63 ++++++
 rtl/wt_inval_queue.sv | 100 ++++++++++
 tb/tb_wt_inval_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wt_cache_pkg.sv
// rtl/wt_cache_pkg.sv - shared write-through cache types and constants
package wt_cache_pkg;

    localparam int unsigned INVAL_LINE_OFFSET = 4;

    typedef struct packed {
        logic [63:0] addr;
    } inval_req_t;

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - synchronous FIFO with occupancy count and optional fall-through
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [ADDR_DEPTH:0]   usage_o
);

    localparam logic [ADDR_DEPTH:0]   FULL_CNT = (ADDR_DEPTH + 1)'(DEPTH);
    localparam logic [ADDR_DEPTH-1:0] PTR_ONE  = ADDR_DEPTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_DEPTH-1:0] rd_ptr_q;
    logic [ADDR_DEPTH-1:0] wr_ptr_q;
    logic [ADDR_DEPTH:0]   cnt_q;
    logic                  bypass;
    logic                  do_push;
    logic                  do_pop;

    // Fall-through on an empty FIFO hands data straight across without storing it.
    always_comb begin
        bypass  = FALL_THROUGH && (cnt_q == '0) && push_i && pop_i;
        do_push = push_i && (cnt_q != FULL_CNT) && !bypass;
        do_pop  = pop_i && (cnt_q != '0);
    end

    assign data_o  = (FALL_THROUGH && (cnt_q == '0)) ? data_i : mem_q[rd_ptr_q];
    assign usage_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            cnt_q <= cnt_q + {{ADDR_DEPTH{1'b0}}, do_push} - {{ADDR_DEPTH{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/wt_inval_queue.sv
// rtl/wt_inval_queue.sv - line-aligning invalidation queue; WT_INVAL_MERGE_EN enables duplicate suppression
module wt_inval_queue
    import wt_cache_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned LINE_OFFSET = INVAL_LINE_OFFSET,
    parameter int unsigned ADDR_W      = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] inval_addr_i,
    input  logic              inval_valid_i,
    output logic              inval_ready_o,
    output logic [ADDR_W-1:0] inval_addr_o,
    output logic              inval_valid_o,
    input  logic              inval_ready_i,
    input  logic              flush_i,
    output logic              empty_o,
    output logic [15:0]       merge_cnt_o
);

    localparam int unsigned       CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << LINE_OFFSET;

    logic [CNT_W-1:0]  usage;
    logic [ADDR_W-1:0] aligned;
    logic              out_of_reset_q;
    logic              full;
    logic              empty;
    logic              push_acc;
    logic              pop;
    logic              merge;
    logic              store;

    // Holds ready low until the first edge after reset release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_of_reset_q <= 1'b0;
        end else begin
            out_of_reset_q <= 1'b1;
        end
    end

    assign aligned       = inval_addr_i & LINE_MASK;
    assign full          = (usage == FULL_CNT);
    assign empty         = (usage == '0);
    assign empty_o       = empty;
    assign inval_ready_o = out_of_reset_q && !full && !flush_i;
    assign inval_valid_o = !empty && !flush_i;
    assign push_acc      = inval_valid_i && inval_ready_o;
    assign pop           = inval_valid_o && inval_ready_i;
    assign store         = push_acc && !merge;

`ifdef WT_INVAL_MERGE_EN
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    inval_req_t  last_q;
    logic [15:0] merge_q;

    // The tail is the last stored line; it is gone if the sole entry pops now.
    assign merge = push_acc && !empty && (aligned == last_q.addr[ADDR_W-1:0])
                   && !(pop && (usage == ONE_CNT));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q  <= '0;
            merge_q <= '0;
        end else begin
            if (store) begin
                last_q.addr <= 64'(aligned);
            end
            if (merge && (merge_q != 16'hFFFF)) begin
                merge_q <= merge_q + 16'd1;
            end
        end
    end

    assign merge_cnt_o = merge_q;
`else
    assign merge       = 1'b0;
    assign merge_cnt_o = '0;
`endif

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (ADDR_W),
        .DEPTH        (DEPTH)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (!rst_i),
        .flush_i (flush_i),
        .push_i  (store),
        .data_i  (aligned),
        .pop_i   (pop),
        .data_o  (inval_addr_o),
        .usage_o (usage)
    );

endmodule

// File: tb/tb_wt_inval_queue.sv
// tb/tb_wt_inval_queue.sv - self-checking bench for wt_inval_queue
module tb_wt_inval_queue;

    localparam int DEPTH = 4;
`ifdef WT_INVAL_MERGE_EN
    localparam bit MERGE_EN = 1'b1;
`else
    localparam bit MERGE_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [63:0] inval_addr_i;
    logic        inval_valid_i;
    logic        inval_ready_o;
    logic [63:0] inval_addr_o;
    logic        inval_valid_o;
    logic        inval_ready_i;
    logic        flush_i;
    logic        empty_o;
    logic [15:0] merge_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    wt_inval_queue dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .inval_addr_i  (inval_addr_i),
        .inval_valid_i (inval_valid_i),
        .inval_ready_o (inval_ready_o),
        .inval_addr_o  (inval_addr_o),
        .inval_valid_o (inval_valid_o),
        .inval_ready_i (inval_ready_i),
        .flush_i       (flush_i),
        .empty_o       (empty_o),
        .merge_cnt_o   (merge_cnt_o)
    );

    typedef struct {
        logic        v;
        logic [63:0] a;
        logic        rdy;
        logic        fl;
        logic        e_ready;
        logic        e_valid;
        logic [63:0] e_addr;
        logic        e_empty;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [63:0] a, logic rdy, logic fl,
                                logic er, logic ev, logic [63:0] ea, logic ee);
        vec_t r;
        r.v = v; r.a = a; r.rdy = rdy; r.fl = fl;
        r.e_ready = er; r.e_valid = ev; r.e_addr = ea; r.e_empty = ee;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: an ordered list of stored lines plus a merge counter.
    logic [63:0] mq[$];
    int          mc;

    logic [63:0] pool [4] = '{64'h8000_0000, 64'h8000_0010, 64'h8000_0020, 64'h0000_1230};

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        int          exp_mc;
        logic        hold;
        logic        m_ready;
        logic        m_valid;
        logic        m_push;
        logic        m_pop;
        logic        dup;
        logic [63:0] al;

        rst_i = 1'b1; inval_valid_i = 1'b0; inval_addr_i = '0;
        inval_ready_i = 1'b0; flush_i = 1'b0;
        tick; tick;
        check("reset_ready", inval_ready_o, 0);
        check("reset_valid", inval_valid_o, 0);
        check("reset_empty", empty_o, 1);
        check("reset_merge", merge_cnt_o, 0);
        check("reset_addr", inval_addr_o, 0);
        rst_i = 1'b0;
        tick;
        #3;
        check("ready_after_reset", inval_ready_o, 1);
        tick;

        vecs.push_back(mk(1, 64'h8000_1237, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 64'h8000_1230, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 64'h100, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 64'h200, 0, 0, 1, 1, 64'h100, 0));
        vecs.push_back(mk(1, 64'h300, 0, 0, 1, 1, 64'h100, 0));
        vecs.push_back(mk(1, 64'h400, 0, 0, 1, 1, 64'h100, 0));
        vecs.push_back(mk(1, 64'h500, 1, 0, 0, 1, 64'h100, 0));
        vecs.push_back(mk(1, 64'h500, 0, 0, 1, 1, 64'h200, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 64'h200, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 64'h300, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 64'h400, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 64'h500, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 64'h600, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 64'h700, 0, 0, 1, 1, 64'h600, 0));
        vecs.push_back(mk(1, 64'h800, 0, 0, 1, 1, 64'h600, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 64'h500, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 64'h500, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 64'h500, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1));

        foreach (vecs[i]) begin
            inval_valid_i = vecs[i].v;
            inval_addr_i  = vecs[i].a;
            inval_ready_i = vecs[i].rdy;
            flush_i       = vecs[i].fl;
            #3;
            check($sformatf("vec%0d_ready", i), inval_ready_o, vecs[i].e_ready);
            check($sformatf("vec%0d_valid", i), inval_valid_o, vecs[i].e_valid);
            check($sformatf("vec%0d_empty", i), empty_o, vecs[i].e_empty);
            if (vecs[i].e_valid)
                check($sformatf("vec%0d_addr", i), inval_addr_o, vecs[i].e_addr);
            tick;
        end
        inval_valid_i = 1'b0; inval_ready_i = 1'b0; flush_i = 1'b0;

        // Duplicate lines with the output stalled.
        inval_valid_i = 1'b1; inval_addr_i = 64'h1000; tick;
        inval_addr_i = 64'h1008; tick;
        inval_addr_i = 64'h1000; tick;
        inval_valid_i = 1'b0; inval_ready_i = 1'b1;
        #3;
        exp_mc = MERGE_EN ? 2 : 0;
        check("merge_cnt", merge_cnt_o, 64'(exp_mc));
        check("merge_not_empty", empty_o, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (!inval_valid_o) break;
            check("merge_drain_addr", inval_addr_o, 64'h1000);
            n++;
            @(posedge clk_i);
            #3;
        end
        check("merge_entries", 64'(n), MERGE_EN ? 64'd1 : 64'd3);
        inval_ready_i = 1'b0;
        tick;

        // Same line pushed while the only entry pops: must be stored again.
        inval_valid_i = 1'b1; inval_addr_i = 64'h2000; tick;
        inval_addr_i = 64'h2004; inval_ready_i = 1'b1;
        #3;
        check("popblk_head", inval_addr_o, 64'h2000);
        tick;
        inval_valid_i = 1'b0; inval_ready_i = 1'b0;
        #3;
        check("popblk_valid", inval_valid_o, 1);
        check("popblk_addr", inval_addr_o, 64'h2000);
        check("popblk_merge", merge_cnt_o, 64'(exp_mc));
        inval_ready_i = 1'b1;
        @(posedge clk_i);
        #3;
        check("popblk_empty", empty_o, 1);
        inval_ready_i = 1'b0;
        tick;

        // Asynchronous reset with entries queued.
        inval_valid_i = 1'b1; inval_addr_i = 64'h3000; tick;
        inval_addr_i = 64'h3010; tick;
        inval_valid_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_valid", inval_valid_o, 0);
        check("arst_empty", empty_o, 1);
        check("arst_ready", inval_ready_o, 0);
        tick;
        rst_i = 1'b0;
        tick;
        #3;
        check("arst_rel_ready", inval_ready_o, 1);
        check("arst_rel_empty", empty_o, 1);
        check("arst_rel_valid", inval_valid_o, 0);
        tick;

        // Randomized traffic against the reference model.
        mq.delete();
        mc = 0;
        hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!hold) begin
                inval_valid_i = ($urandom_range(3) != 0);
                inval_addr_i  = pool[$urandom_range(3)] | 64'($urandom_range(15));
            end
            inval_ready_i = ((c % 64) < 20) ? ($urandom_range(7) == 0) : ($urandom_range(2) != 0);
            flush_i       = ($urandom_range(31) == 0);
            #3;
            m_ready = (mq.size() < DEPTH) && !flush_i;
            m_valid = (mq.size() > 0) && !flush_i;
            check("rnd_ready", inval_ready_o, m_ready);
            check("rnd_valid", inval_valid_o, m_valid);
            check("rnd_empty", empty_o, mq.size() == 0);
            check("rnd_merge", merge_cnt_o, 64'(mc));
            if (m_valid)
                check("rnd_addr", inval_addr_o, mq[0]);
            if (flush_i) begin
                mq.delete();
            end else begin
                al     = inval_addr_i & ~64'hF;
                m_push = inval_valid_i && m_ready;
                m_pop  = m_valid && inval_ready_i;
                dup    = MERGE_EN && m_push && (mq.size() > 0) && (al == mq[mq.size()-1])
                         && !(m_pop && mq.size() == 1);
                if (m_pop) void'(mq.pop_front());
                if (m_push && !dup) mq.push_back(al);
                if (dup && mc < 65535) mc++;
            end
            hold = inval_valid_i && !m_ready;
            @(posedge clk_i);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
